// File: rtl/fnd_pkg.sv
// Shared constants for the 7-segment scan driver: active-low segment
// patterns (bit 0 = a ... bit 6 = g) and the clock divider helper.
package fnd_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    // Integer divide that never yields less than 1, so a divider always counts.
    function automatic int div_min1(input int a, input int b);
        int q;
        q = a / b;
        return (q < 1) ? 1 : q;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD values show a dash.
module bcd_to_seg
    import fnd_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Look up the digit pattern, falling back to a dash for values above 9.
    always_comb begin
        seg = SEG_DASH;
        if (bcd <= 4'd9) begin
            seg = SEG_DIGIT[bcd];
        end
    end

endmodule

// File: rtl/fnd_scan_driver.sv
// Time-multiplexed 4-digit common-anode display driver showing mm.ss.
// Keeps a BCD minutes count advanced by seconds wrapping 59 -> 00 and blinks
// the mm/ss separator while the stopwatch runs.
module fnd_scan_driver
    import fnd_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLINK_HZ = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [3:0]            NUM_1s,
    input  logic [2:0]            NUM_10s,
    output logic [NUM_DIGITS-1:0] AN,
    output logic [6:0]            SEG,
    output logic                  DP
);

    localparam int SCAN_DIV  = div_min1(CLK_FREQ, SCAN_HZ);
    localparam int BLINK_DIV = div_min1(CLK_FREQ, 2 * BLINK_HZ);
    localparam int SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [SCAN_W-1:0]  scan_cnt;
    logic               tick;
    logic [1:0]         idx;
    logic [3:0]         min_1s;
    logic [3:0]         min_10s;
    logic [6:0]         prev_sec;
    logic               wrap;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_ph;
    logic [3:0]         digit_val;
    logic               blank;
    logic [6:0]         seg_pat;

    assign tick = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign wrap = (prev_sec == {3'd5, 4'd9}) && ({NUM_10s, NUM_1s} == 7'd0);

    // Scan prescaler: free-running 0..SCAN_DIV-1.
    always_ff @(posedge CLK) begin
        if (RST || tick) scan_cnt <= '0;
        else             scan_cnt <= scan_cnt + 1'b1;
    end

    // Digit index advances once per scan tick, wrapping 3 -> 0.
    always_ff @(posedge CLK) begin
        if (RST)       idx <= '0;
        else if (tick) idx <= idx + 2'd1;
    end

    // Previous seconds value, used to spot the 59 -> 00 wrap.
    always_ff @(posedge CLK) begin
        if (RST) prev_sec <= '0;
        else     prev_sec <= {NUM_10s, NUM_1s};
    end

    // BCD minutes counter 00..99, stepped on each seconds wrap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            min_1s  <= '0;
            min_10s <= '0;
        end else if (wrap) begin
            if (min_1s == 4'd9) begin
                min_1s  <= '0;
                min_10s <= (min_10s == 4'd9) ? 4'd0 : min_10s + 4'd1;
            end else begin
                min_1s <= min_1s + 4'd1;
            end
        end
    end

    // Separator blink: phase toggles every BLINK_DIV cycles while running,
    // parked at the lit phase when stopped.
    always_ff @(posedge CLK) begin
        if (RST || !start) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b1;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Digit mux and leading-zero blanking of the minutes tens digit.
    always_comb begin
        digit_val = NUM_1s;
        blank     = 1'b0;
        case (idx)
            2'd0: digit_val = NUM_1s;
            2'd1: digit_val = {1'b0, NUM_10s};
            2'd2: digit_val = min_1s;
            2'd3: begin
                digit_val = min_10s;
                blank     = (min_10s == 4'd0);
            end
            default: digit_val = NUM_1s;
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .bcd (digit_val),
        .seg (seg_pat)
    );

    // AN, SEG and DP registered together so the digit switch is glitch-free.
    always_ff @(posedge CLK) begin
        if (RST) begin
            AN  <= '1;
            SEG <= SEG_OFF;
            DP  <= 1'b1;
        end else begin
            AN  <= blank ? '1 : ~(NUM_DIGITS'(1) << idx);
            SEG <= blank ? SEG_OFF : seg_pat;
            DP  <= (idx == 2'd2) ? ~blink_ph : 1'b1;
        end
    end

endmodule
